// File: rtl/debug_pkg.sv
// Shared definitions for the pipeline debug sequencer: command bytes,
// FSM states and status-byte layout.
package debug_pkg;

  localparam logic [7:0] CMD_LOAD  = 8'h4C;
  localparam logic [7:0] CMD_RUN   = 8'h52;
  localparam logic [7:0] CMD_STEP  = 8'h53;
  localparam logic [7:0] CMD_CLEAR = 8'h43;

  localparam int ST_HALTED  = 0;
  localparam int ST_TIMEOUT = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_CNT,
    S_LD_BYTE,
    S_LD_WR,
    S_RUN,
    S_STEP,
    S_REPORT
  } dbg_state_e;

  function automatic logic [7:0] status_byte(input logic halted, input logic timeout);
    logic [7:0] s;
    s = '0;
    s[ST_HALTED]  = halted;
    s[ST_TIMEOUT] = timeout;
    return s;
  endfunction

endpackage

// File: rtl/debug_tx_serializer.sv
// Shifts out an NBITS PC (LSB byte first) followed by a status byte on a
// valid/ready byte interface; pulses o_done on the final accept.
module debug_tx_serializer #(
  parameter int NBITS = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [NBITS-1:0] i_pc,
  input  logic [7:0]       i_status,
  input  logic             i_tx_ready,
  output logic [7:0]       o_tx_data,
  output logic             o_tx_valid,
  output logic             o_done
);
  localparam int NB = NBITS / 8 + 1;
  localparam int CW = $clog2(NB);

  logic [NBITS+7:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             active_q, active_d;

  always_comb begin
    sreg_d   = sreg_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    o_done   = 1'b0;
    if (i_load) begin
      sreg_d   = {i_status, i_pc};
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q && i_tx_ready) begin
      if (cnt_q == CW'(NB - 1)) begin
        active_d = 1'b0;
        o_done   = 1'b1;
      end else begin
        sreg_d = sreg_q >> 8;
        cnt_d  = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sreg_q   <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      sreg_q   <= sreg_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign o_tx_valid = active_q;
  assign o_tx_data  = active_q ? sreg_q[7:0] : 8'h00;

endmodule

// File: rtl/pipeline_debug_controller.sv
// UART-driven debug sequencer: loads instruction memory, runs/steps/clears
// the pipeline and reports PC plus status after each run or step.
module pipeline_debug_controller
  import debug_pkg::*;
#(
  parameter int NBITS   = 32,
  parameter int TIMEOUT = 1000000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_valid,
  output logic [7:0]       o_tx_data,
  output logic             o_tx_valid,
  input  logic             i_tx_ready,
  output logic             o_inst_mem_wr_en,
  output logic [NBITS-1:0] o_inst_mem_addr,
  output logic [NBITS-1:0] o_inst_mem_data,
  output logic             o_pipe_en,
  output logic             o_pipe_rst,
  input  logic             i_halt,
  input  logic [NBITS-1:0] i_pc,
  output logic [NBITS-1:0] o_cycle_count,
  output logic             o_busy
);
  localparam int BPW = NBITS / 8;
  localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1;

  dbg_state_e       state_q, state_d;
  logic [7:0]       nwords_q, nwords_d;
  logic [7:0]       widx_q, widx_d;
  logic [BIW-1:0]   bidx_q, bidx_d;
  logic [NBITS-1:0] word_q, word_d;
  logic [NBITS-1:0] mem_addr_q, mem_addr_d;
  logic [NBITS-1:0] mem_data_q, mem_data_d;
  logic [NBITS-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0]      run_cnt_q, run_cnt_d;
  logic [7:0]       status_q, status_d;
  logic             pipe_rst_q, pipe_rst_d;
  logic             rpt_start_q, rpt_start_d;
  logic             pipe_en;
  logic             ser_done;

  assign pipe_en = (state_q == S_RUN) || (state_q == S_STEP);

  always_comb begin
    state_d     = state_q;
    nwords_d    = nwords_q;
    widx_d      = widx_q;
    bidx_d      = bidx_q;
    word_d      = word_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    cycle_cnt_d = pipe_en ? cycle_cnt_q + 1'b1 : cycle_cnt_q;
    run_cnt_d   = run_cnt_q;
    status_d    = status_q;
    pipe_rst_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        run_cnt_d = '0;
        if (i_rx_valid) begin
          case (i_rx_data)
            CMD_LOAD: state_d = S_LD_CNT;
            // HALT already at writeback: report immediately, no enabled cycles
            CMD_RUN: begin
              if (i_halt) begin
                status_d = status_byte(1'b1, 1'b0);
                state_d  = S_REPORT;
              end else begin
                state_d = S_RUN;
              end
            end
            CMD_STEP: state_d = S_STEP;
            CMD_CLEAR: begin
              pipe_rst_d  = 1'b1;
              cycle_cnt_d = '0;
            end
            default: ;
          endcase
        end
      end
      S_LD_CNT: begin
        if (i_rx_valid) begin
          nwords_d = i_rx_data;
          widx_d   = '0;
          bidx_d   = '0;
          state_d  = (i_rx_data == 8'h00) ? S_IDLE : S_LD_BYTE;
        end
      end
      S_LD_BYTE: begin
        if (i_rx_valid) begin
          word_d[8*bidx_q +: 8] = i_rx_data;
          bidx_d = bidx_q + 1'b1;
          if (bidx_q == BIW'(BPW - 1)) begin
            mem_data_d = word_d;
            mem_addr_d = NBITS'({widx_q, 2'b00});
            state_d    = S_LD_WR;
          end
        end
      end
      S_LD_WR: begin
        bidx_d = '0;
        if (widx_q == 8'(nwords_q - 8'd1)) begin
          state_d = S_IDLE;
        end else begin
          widx_d  = widx_q + 8'd1;
          state_d = S_LD_BYTE;
        end
      end
      S_RUN: begin
        run_cnt_d = run_cnt_q + 32'd1;
        // halt wins when it coincides with the last timeout cycle
        if (i_halt) begin
          status_d = status_byte(1'b1, 1'b0);
          state_d  = S_REPORT;
        end else if (run_cnt_q == 32'(TIMEOUT - 1)) begin
          status_d = status_byte(1'b0, 1'b1);
          state_d  = S_REPORT;
        end
      end
      S_STEP: begin
        status_d = 8'h00;
        state_d  = S_REPORT;
      end
      S_REPORT: begin
        if (ser_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    rpt_start_d = (state_d == S_REPORT) && (state_q != S_REPORT);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= S_IDLE;
      nwords_q    <= '0;
      widx_q      <= '0;
      bidx_q      <= '0;
      word_q      <= '0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      cycle_cnt_q <= '0;
      run_cnt_q   <= '0;
      status_q    <= '0;
      pipe_rst_q  <= 1'b0;
      rpt_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      nwords_q    <= nwords_d;
      widx_q      <= widx_d;
      bidx_q      <= bidx_d;
      word_q      <= word_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      cycle_cnt_q <= cycle_cnt_d;
      run_cnt_q   <= run_cnt_d;
      status_q    <= status_d;
      pipe_rst_q  <= pipe_rst_d;
      rpt_start_q <= rpt_start_d;
    end
  end

  // PC is captured in the first REPORT cycle, after the last enabled edge
  debug_tx_serializer #(.NBITS(NBITS)) u_ser (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (rpt_start_q),
    .i_pc       (i_pc),
    .i_status   (status_q),
    .i_tx_ready (i_tx_ready),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
    .o_done     (ser_done)
  );

  assign o_inst_mem_wr_en = (state_q == S_LD_WR);
  assign o_inst_mem_addr  = mem_addr_q;
  assign o_inst_mem_data  = mem_data_q;
  assign o_pipe_en        = pipe_en;
  assign o_pipe_rst       = pipe_rst_q;
  assign o_cycle_count    = cycle_cnt_q;
  assign o_busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_pipeline_debug_controller.sv
// Directed bench for pipeline_debug_controller with hand-computed expectations.
module tb_pipeline_debug_controller;
  localparam int NB = 32;
  localparam int TO = 16;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [7:0]    i_rx_data;
  logic          i_rx_valid;
  logic [7:0]    o_tx_data;
  logic          o_tx_valid;
  logic          i_tx_ready;
  logic          o_inst_mem_wr_en;
  logic [NB-1:0] o_inst_mem_addr;
  logic [NB-1:0] o_inst_mem_data;
  logic          o_pipe_en;
  logic          o_pipe_rst;
  logic          i_halt;
  logic [NB-1:0] i_pc;
  logic [NB-1:0] o_cycle_count;
  logic          o_busy;

  always #5 i_clk = ~i_clk;

  pipeline_debug_controller #(.NBITS(NB), .TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
    .o_inst_mem_wr_en(o_inst_mem_wr_en), .o_inst_mem_addr(o_inst_mem_addr),
    .o_inst_mem_data(o_inst_mem_data),
    .o_pipe_en(o_pipe_en), .o_pipe_rst(o_pipe_rst),
    .i_halt(i_halt), .i_pc(i_pc),
    .o_cycle_count(o_cycle_count), .o_busy(o_busy)
  );

  int n_chk = 0;
  int n_fail = 0;
  int pe_total = 0;
  int rst_total = 0;
  logic [7:0]  tx_q[$];
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];

  always @(negedge i_clk) begin
    if (o_inst_mem_wr_en) begin
      wa_q.push_back(o_inst_mem_addr);
      wd_q.push_back(o_inst_mem_data);
    end
    if (o_tx_valid && i_tx_ready) tx_q.push_back(o_tx_data);
    if (o_pipe_en)  pe_total  <= pe_total + 1;
    if (o_pipe_rst) rst_total <= rst_total + 1;
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge i_clk); #1;
    i_rx_data = b; i_rx_valid = 1'b1;
    @(posedge i_clk); #1;
    i_rx_valid = 1'b0; i_rx_data = 8'h00;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (o_busy && k < 200) begin
      @(posedge i_clk); #1;
      k++;
    end
    n_chk++;
    if (o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: still busy after bound, busy=%b required 0", nm, o_busy);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b0; i_rx_data = 8'h00; i_rx_valid = 1'b0; i_tx_ready = 1'b1;
    i_halt = 1'b0; i_pc = '0;
    repeat (3) @(posedge i_clk);
    #1;
    n_chk++;
    if ({o_busy, o_pipe_en, o_pipe_rst, o_inst_mem_wr_en, o_tx_valid, o_tx_data} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 0",
               {o_busy, o_pipe_en, o_pipe_rst, o_inst_mem_wr_en, o_tx_valid, o_tx_data});
    end
    n_chk++;
    if ({o_inst_mem_addr, o_inst_mem_data} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_mem: addr=%h data=%h required 0", o_inst_mem_addr, o_inst_mem_data);
    end
    n_chk++;
    if (o_cycle_count !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_count: got %0d required 0", o_cycle_count);
    end
    i_rst = 1'b1;
  endtask

  task automatic test_load();
    int w0;
    w0 = wa_q.size();
    send_byte(8'h58);
    n_chk++;
    if (o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_byte: busy=%b required 0", o_busy);
    end
    send_byte(8'h4C); send_byte(8'd2);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    wait_idle("load_idle");
    n_chk++;
    if (wa_q.size() - w0 != 2) begin
      n_fail++;
      $display("FAIL load_wr_count: got %0d required 2", wa_q.size() - w0);
    end else begin
      n_chk++;
      if (wa_q[w0] !== 32'h0 || wd_q[w0] !== 32'h44332211) begin
        n_fail++;
        $display("FAIL load_word0: addr=%h data=%h required 0/44332211", wa_q[w0], wd_q[w0]);
      end
      n_chk++;
      if (wa_q[w0+1] !== 32'h4 || wd_q[w0+1] !== 32'h88776655) begin
        n_fail++;
        $display("FAIL load_word1: addr=%h data=%h required 4/88776655", wa_q[w0+1], wd_q[w0+1]);
      end
    end
    n_chk++;
    if (o_inst_mem_wr_en !== 1'b0 || o_inst_mem_addr !== 32'h4 || o_inst_mem_data !== 32'h88776655) begin
      n_fail++;
      $display("FAIL load_hold: wr=%b addr=%h data=%h required 0/4/88776655",
               o_inst_mem_wr_en, o_inst_mem_addr, o_inst_mem_data);
    end
  endtask

  task automatic test_step();
    int w0, pe0, t0;
    logic [7:0] exp[5];
    exp = '{8'hD8, 8'hC7, 8'hB6, 8'hA5, 8'h00};
    w0 = wa_q.size(); pe0 = pe_total; t0 = tx_q.size();
    i_pc = 32'hA5B6C7D8;
    send_byte(8'h4C); send_byte(8'd0);
    n_chk++;
    if (o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL load_zero_idle: busy=%b required 0", o_busy);
    end
    send_byte(8'h53);
    n_chk++;
    if (o_pipe_en !== 1'b1) begin
      n_fail++;
      $display("FAIL step_latency: pipe_en=%b required 1", o_pipe_en);
    end
    @(posedge i_clk); #1;
    n_chk++;
    if (o_pipe_en !== 1'b0) begin
      n_fail++;
      $display("FAIL step_single: pipe_en=%b required 0", o_pipe_en);
    end
    wait_idle("step_idle");
    n_chk++;
    if (wa_q.size() != w0 || pe_total - pe0 != 1) begin
      n_fail++;
      $display("FAIL step_counts: writes=%0d pe=%0d required 0/1", wa_q.size() - w0, pe_total - pe0);
    end
    n_chk++;
    if (tx_q.size() - t0 != 5) begin
      n_fail++;
      $display("FAIL step_tx_len: got %0d required 5", tx_q.size() - t0);
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_chk++;
        if (tx_q[t0+i] !== exp[i]) begin
          n_fail++;
          $display("FAIL step_tx_byte%0d: got %h required %h", i, tx_q[t0+i], exp[i]);
        end
      end
    end
    n_chk++;
    if (o_cycle_count !== 32'd1) begin
      n_fail++;
      $display("FAIL step_count: got %0d required 1", o_cycle_count);
    end
  endtask

  task automatic test_run_halt();
    int pe0, t0;
    logic [7:0] exp[5];
    exp = '{8'h34, 8'h12, 8'h00, 8'h00, 8'h01};
    i_pc = 32'h00001234; i_halt = 1'b0;
    pe0 = pe_total; t0 = tx_q.size();
    send_byte(8'h52);
    repeat (6) @(posedge i_clk);
    #1 i_halt = 1'b1;
    wait_idle("run_idle");
    i_halt = 1'b0;
    n_chk++;
    if (pe_total - pe0 != 7 || o_cycle_count !== 32'd8) begin
      n_fail++;
      $display("FAIL run_halt_cycles: pe=%0d count=%0d required 7/8", pe_total - pe0, o_cycle_count);
    end
    n_chk++;
    if (tx_q.size() - t0 != 5) begin
      n_fail++;
      $display("FAIL run_tx_len: got %0d required 5", tx_q.size() - t0);
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_chk++;
        if (tx_q[t0+i] !== exp[i]) begin
          n_fail++;
          $display("FAIL run_tx_byte%0d: got %h required %h", i, tx_q[t0+i], exp[i]);
        end
      end
    end
    // halt already high when RUN arrives
    i_halt = 1'b1;
    pe0 = pe_total; t0 = tx_q.size();
    send_byte(8'h52);
    wait_idle("run_preh_idle");
    i_halt = 1'b0;
    n_chk++;
    if (pe_total - pe0 != 0 || tx_q.size() - t0 != 5) begin
      n_fail++;
      $display("FAIL run_prehalt: pe=%0d bytes=%0d required 0/5", pe_total - pe0, tx_q.size() - t0);
    end else begin
      n_chk++;
      if (tx_q[t0+4] !== 8'h01) begin
        n_fail++;
        $display("FAIL run_prehalt_status: got %h required 01", tx_q[t0+4]);
      end
    end
  endtask

  task automatic test_timeout();
    int pe0, t0;
    i_pc = 32'hDEADBEEF; i_halt = 1'b0;
    pe0 = pe_total; t0 = tx_q.size();
    send_byte(8'h52);
    wait_idle("timeout_idle");
    n_chk++;
    if (pe_total - pe0 != 16 || o_cycle_count !== 32'd24) begin
      n_fail++;
      $display("FAIL timeout_cycles: pe=%0d count=%0d required 16/24", pe_total - pe0, o_cycle_count);
    end
    n_chk++;
    if (tx_q.size() - t0 != 5 || tx_q[t0] !== 8'hEF || tx_q[t0+4] !== 8'h02) begin
      n_fail++;
      $display("FAIL timeout_report: bytes=%0d b0=%h status=%h required 5/EF/02",
               tx_q.size() - t0, tx_q[t0], tx_q[t0+4]);
    end
    // halt on the final timeout cycle reports halted only
    pe0 = pe_total; t0 = tx_q.size();
    send_byte(8'h52);
    repeat (15) @(posedge i_clk);
    #1 i_halt = 1'b1;
    wait_idle("tohalt_idle");
    i_halt = 1'b0;
    n_chk++;
    if (pe_total - pe0 != 16 || tx_q.size() - t0 != 5 || tx_q[t0+4] !== 8'h01) begin
      n_fail++;
      $display("FAIL timeout_halt_same: pe=%0d bytes=%0d status=%h required 16/5/01",
               pe_total - pe0, tx_q.size() - t0, tx_q[t0+4]);
    end
  endtask

  task automatic test_report_stall();
    int t0, rst0, k;
    logic [7:0] exp[5];
    exp = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
    i_pc = 32'h01020304;
    t0 = tx_q.size(); rst0 = rst_total;
    send_byte(8'h53);
    k = 0;
    while (tx_q.size() - t0 < 2 && k < 50) begin
      @(posedge i_clk); #1;
      k++;
    end
    i_tx_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge i_clk); #1;
      if (i == 3) begin i_rx_data = 8'h43; i_rx_valid = 1'b1; end
      if (i == 4) begin i_rx_data = 8'h00; i_rx_valid = 1'b0; end
      n_chk++;
      if (o_tx_valid !== 1'b1 || o_tx_data !== 8'h02) begin
        n_fail++;
        $display("FAIL stall_hold%0d: valid=%b data=%h required 1/02", i, o_tx_valid, o_tx_data);
      end
    end
    i_tx_ready = 1'b1;
    wait_idle("stall_idle");
    n_chk++;
    if (tx_q.size() - t0 != 5) begin
      n_fail++;
      $display("FAIL stall_tx_len: got %0d required 5", tx_q.size() - t0);
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_chk++;
        if (tx_q[t0+i] !== exp[i]) begin
          n_fail++;
          $display("FAIL stall_tx_byte%0d: got %h required %h", i, tx_q[t0+i], exp[i]);
        end
      end
    end
    n_chk++;
    if (rst_total != rst0 || o_cycle_count !== 32'd41) begin
      n_fail++;
      $display("FAIL stall_clear_ignored: rst=%0d count=%0d required 0/41", rst_total - rst0, o_cycle_count);
    end
    send_byte(8'h43);
    n_chk++;
    if (o_pipe_rst !== 1'b1 || o_cycle_count !== 32'd0) begin
      n_fail++;
      $display("FAIL clear_pulse: pipe_rst=%b count=%0d required 1/0", o_pipe_rst, o_cycle_count);
    end
    @(posedge i_clk); #1;
    n_chk++;
    if (o_pipe_rst !== 1'b0 || rst_total - rst0 != 1 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_once: pipe_rst=%b pulses=%0d busy=%b required 0/1/0",
               o_pipe_rst, rst_total - rst0, o_busy);
    end
  endtask

  task automatic test_reset_midload();
    int w0;
    send_byte(8'h4C); send_byte(8'd3); send_byte(8'h01); send_byte(8'h02);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    #1;
    n_chk++;
    if ({o_busy, o_inst_mem_wr_en, o_pipe_en, o_tx_valid} !== 4'h0 ||
        o_inst_mem_addr !== 32'h0 || o_inst_mem_data !== 32'h0) begin
      n_fail++;
      $display("FAIL midload_reset: busy=%b addr=%h data=%h required 0/0/0",
               o_busy, o_inst_mem_addr, o_inst_mem_data);
    end
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b1;
    w0 = wa_q.size();
    send_byte(8'h4C); send_byte(8'd1);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    wait_idle("reload_idle");
    n_chk++;
    if (wa_q.size() - w0 != 1) begin
      n_fail++;
      $display("FAIL reload_wr_count: got %0d required 1", wa_q.size() - w0);
    end else begin
      n_chk++;
      if (wa_q[w0] !== 32'h0 || wd_q[w0] !== 32'hDDCCBBAA) begin
        n_fail++;
        $display("FAIL reload_word: addr=%h data=%h required 0/DDCCBBAA", wa_q[w0], wd_q[w0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_step();
    test_run_halt();
    test_timeout();
    test_report_stall();
    test_reset_midload();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
